// File: rtl/apb_chip_ctrl_regs_pkg.sv
// Shared definitions for the chip-control register block: register offsets,
// STATUS bit positions and the divider handshake state type.
package chip_ctrl_reg_pkg;

    localparam int OFF_INFO   = 'h000;
    localparam int OFF_BYPASS = 'h004;
    localparam int OFF_CLKDIV = 'h008;
    localparam int OFF_STATUS = 'h00C;
    localparam int OFF_PADMUX = 'h100;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_TIMEOUT = 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} div_state_e;

endpackage

// File: rtl/apb_chip_ctrl_regs_if.sv
// APB completer-side bus bundle; the master modport drives requests, the slave
// modport returns read data and completion.
interface apb_chip_ctrl_regs_if;
    logic [31:0] paddr_i;
    logic [2:0]  pprot_i;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [3:0]  pstrb_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    // Transfer completes on the rising edge where psel, penable and pready are all high.
    modport master (
        output paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );
    modport slave (
        input  paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_chip_ctrl_regs_div_hs.sv
// Divider update handshake: presents a value with req until the clock generator
// acknowledges or the wait budget runs out.
module chip_ctrl_div_hs
    import chip_ctrl_reg_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] value_i,
    input  logic       ack_i,
    output logic       div_req_o,
    output logic [7:0] div_value_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       set_timeout_o,
    output div_state_e state_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       value_q, value_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            value_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        value_d       = value_q;
        set_timeout_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    value_d = value_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // cnt_d counts elapsed wait cycles; an ack on the last one still wins
                cnt_d = cnt_q + 1'b1;
                if (ack_i) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    err_d         = 1'b1;
                    set_timeout_o = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_req_o   = (state_q == WAIT);
    assign div_value_o = value_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign state_o     = state_q;
endmodule

// File: rtl/apb_chip_ctrl_regs.sv
// Chip-control APB register block: pad-mux selects, FLL bypass and a peripheral
// clock divider whose writes stall the bus for the clock-generator handshake.
module apb_chip_ctrl_regs
    import chip_ctrl_reg_pkg::*;
#(
    parameter int NPADS   = 48,
    parameter int MUX_W   = 2,
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 12
) (
    input  logic                   soc_clk_i,
    input  logic                   soc_rst_i,
    apb_chip_ctrl_regs_if.slave    apb,
    output logic [NPADS*MUX_W-1:0] padmux_o,
    output logic                   bypass_fll_o,
    output logic [7:0]             div_value_o,
    output logic                   div_req_o,
    input  logic                   div_ack_i,
    output div_state_e             dbg_div_state_o
);
    localparam int NWORDS = NPADS * MUX_W / 32;

    logic [NPADS*MUX_W-1:0] padmux_q, padmux_d;
    logic                   bypass_q, bypass_d;
    logic [7:0]             clkdiv_q, clkdiv_d;
    logic                   tout_q, tout_d;

    logic [ADDR_W-1:0] addr, pad_off;
    logic [ADDR_W-3:0] pad_word;
    logic is_info, is_bypass, is_clkdiv, is_status, is_pad, mapped;
    logic access, wr_ok, hs_start;
    logic hs_busy, hs_done, hs_err, hs_set_timeout;
    logic [31:0] rdata;

    assign addr      = apb.paddr_i[ADDR_W-1:0];
    assign pad_off   = addr - ADDR_W'(OFF_PADMUX);
    assign pad_word  = pad_off[ADDR_W-1:2];
    assign is_info   = (addr == ADDR_W'(OFF_INFO));
    assign is_bypass = (addr == ADDR_W'(OFF_BYPASS));
    assign is_clkdiv = (addr == ADDR_W'(OFF_CLKDIV));
    assign is_status = (addr == ADDR_W'(OFF_STATUS));
    assign is_pad    = (addr >= ADDR_W'(OFF_PADMUX)) && (addr < ADDR_W'(OFF_PADMUX + 4 * NWORDS))
                       && (addr[1:0] == 2'b00);
    assign mapped    = is_info | is_bypass | is_clkdiv | is_status | is_pad;

    // New accesses are only decoded while no divider handshake is in flight.
    assign access   = apb.psel_i & apb.penable_i & ~hs_busy;
    assign wr_ok    = access & apb.pwrite_i & mapped;
    assign hs_start = wr_ok & is_clkdiv & apb.pstrb_i[0];

    chip_ctrl_div_hs #(.TIMEOUT(TIMEOUT)) u_div_hs (
        .clk_i        (soc_clk_i),
        .rst_i        (soc_rst_i),
        .start_i      (hs_start),
        .value_i      (apb.pwdata_i[7:0]),
        .ack_i        (div_ack_i),
        .div_req_o    (div_req_o),
        .div_value_o  (div_value_o),
        .busy_o       (hs_busy),
        .done_o       (hs_done),
        .err_o        (hs_err),
        .set_timeout_o(hs_set_timeout),
        .state_o      (dbg_div_state_o)
    );

    always_comb begin
        rdata = 32'h0;
        if (is_info)   rdata = {16'h0, 16'(NPADS)};
        if (is_bypass) rdata = {31'h0, bypass_q};
        if (is_clkdiv) rdata = {24'h0, clkdiv_q};
        if (is_status) rdata = {30'h0, tout_q, hs_busy};
        for (int w = 0; w < NWORDS; w++) begin
            if (is_pad && pad_word == (ADDR_W-2)'(w)) rdata = padmux_q[32*w +: 32];
        end
    end

    always_comb begin
        apb.prdata_o  = 32'h0;
        apb.pready_o  = 1'b0;
        apb.pslverr_o = 1'b0;
        if (hs_done) begin
            apb.pready_o  = 1'b1;
            apb.pslverr_o = hs_err;
        end else if (access) begin
            if (!mapped) begin
                apb.pready_o  = 1'b1;
                apb.pslverr_o = 1'b1;
            end else if (!hs_start) begin
                apb.pready_o = 1'b1;
                if (!apb.pwrite_i) apb.prdata_o = rdata;
            end
        end
    end

    always_comb begin
        padmux_d = padmux_q;
        bypass_d = bypass_q;
        clkdiv_d = clkdiv_q;
        tout_d   = tout_q;
        for (int w = 0; w < NWORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_ok && is_pad && pad_word == (ADDR_W-2)'(w) && apb.pstrb_i[b])
                    padmux_d[32*w + 8*b +: 8] = apb.pwdata_i[8*b +: 8];
            end
        end
        if (wr_ok && is_bypass && apb.pstrb_i[0]) bypass_d = apb.pwdata_i[0];
        if (hs_done && !hs_err) clkdiv_d = div_value_o;
        if (wr_ok && is_status && apb.pstrb_i[0] && apb.pwdata_i[STATUS_TIMEOUT]) tout_d = 1'b0;
        if (hs_set_timeout) tout_d = 1'b1;
    end

    always_ff @(posedge soc_clk_i or posedge soc_rst_i) begin
        if (soc_rst_i) begin
            padmux_q <= '0;
            bypass_q <= 1'b0;
            clkdiv_q <= 8'h00;
            tout_q   <= 1'b0;
        end else begin
            padmux_q <= padmux_d;
            bypass_q <= bypass_d;
            clkdiv_q <= clkdiv_d;
            tout_q   <= tout_d;
        end
    end

    assign padmux_o     = padmux_q;
    assign bypass_fll_o = bypass_q;

    logic unused_bits;
    assign unused_bits = ^{apb.pprot_i, apb.paddr_i[31:ADDR_W], pad_off[1:0]};
endmodule

// File: tb/tb_apb_chip_ctrl_regs.sv
// Self-checking bench for apb_chip_ctrl_regs: directed vector table, handshake
// corner sequences and random traffic against a register-map model.
module tb_apb_chip_ctrl_regs;
    import chip_ctrl_reg_pkg::*;

    logic        soc_clk = 1'b0;
    logic        soc_rst = 1'b1;
    logic [95:0] padmux;
    logic        bypass, div_req, div_ack;
    logic [7:0]  div_value;
    div_state_e  dbg_state;
    int          n_checks = 0;
    int          n_pass   = 0;

    apb_chip_ctrl_regs_if apb_bus ();

    apb_chip_ctrl_regs dut (
        .soc_clk_i      (soc_clk),
        .soc_rst_i      (soc_rst),
        .apb            (apb_bus),
        .padmux_o       (padmux),
        .bypass_fll_o   (bypass),
        .div_value_o    (div_value),
        .div_req_o      (div_req),
        .div_ack_i      (div_ack),
        .dbg_div_state_o(dbg_state)
    );

    always #5 soc_clk = ~soc_clk;

    // ---------------- reference model ----------------
    logic [31:0] m_pad [3];
    logic        m_bypass;
    logic [7:0]  m_clkdiv;
    logic        m_tout;

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_pad[i] = 32'h0;
        m_bypass = 1'b0;
        m_clkdiv = 8'h00;
        m_tout   = 1'b0;
    endtask

    function automatic bit m_is_pad(input logic [31:0] addr);
        int a = int'(addr % 4096);
        return (a >= 'h100) && (a < 'h10C) && (a % 4 == 0);
    endfunction

    function automatic bit m_mapped(input logic [31:0] addr);
        int a = int'(addr % 4096);
        return (a == 0) || (a == 4) || (a == 8) || (a == 12) || m_is_pad(addr);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        int a = int'(addr % 4096);
        if (a == 0)  return 32'd48;
        if (a == 4)  return {31'h0, m_bypass};
        if (a == 8)  return {24'h0, m_clkdiv};
        if (a == 12) return m_tout ? 32'h2 : 32'h0;
        if (m_is_pad(addr)) return m_pad[(a - 'h100) / 4];
        return 32'h0;
    endfunction

    task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int a = int'(addr % 4096);
        if (a == 4 && strb[0]) m_bypass = data[0];
        if (a == 12 && strb[0] && data[1]) m_tout = 1'b0;
        if (m_is_pad(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_pad[(a - 'h100) / 4][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // ---------------- checking and drivers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rd, output logic err,
                            output int cyc);
        @(negedge soc_clk);
        apb_bus.psel_i    = 1'b1;
        apb_bus.penable_i = 1'b0;
        apb_bus.pwrite_i  = wr;
        apb_bus.paddr_i   = addr;
        apb_bus.pwdata_i  = data;
        apb_bus.pstrb_i   = strb;
        apb_bus.pprot_i   = 3'($urandom_range(0, 7));
        @(negedge soc_clk);
        apb_bus.penable_i = 1'b1;
        #1;
        cyc = 1;
        while (apb_bus.pready_o !== 1'b1 && cyc < 400) begin
            @(negedge soc_clk);
            #1;
            cyc++;
        end
        rd  = apb_bus.prdata_o;
        err = apb_bus.pslverr_o;
        if (apb_bus.pready_o !== 1'b1) begin
            n_checks++;
            $display("FAIL xfer_timeout: addr 0x%08h got no pready within %0d cycles", addr, cyc);
        end
        @(posedge soc_clk);
        #1;
        apb_bus.psel_i    = 1'b0;
        apb_bus.penable_i = 1'b0;
    endtask

    // Acks n cycles after req is first observed, checking the presented value.
    task automatic ack_after(input int n, input logic [7:0] exp_val);
        int k = 0;
        while (div_req !== 1'b1 && k < 50) begin
            @(negedge soc_clk);
            #1;
            k++;
        end
        check("req_seen", {31'h0, div_req}, 32'h1);
        if (div_req === 1'b1) begin
            check("div_value_req", {24'h0, div_value}, {24'h0, exp_val});
            repeat (n) @(negedge soc_clk);
            div_ack = 1'b1;
            @(negedge soc_clk);
            div_ack = 1'b0;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [18];
    logic [31:0] rd;
    logic        err;
    int          cyc;
    logic [31:0] pick_addr [10];

    initial begin
        vecs[0]  = '{1'b0, 32'h000, 32'h0,         4'h0,    32'h00000030, 1'b0};
        vecs[1]  = '{1'b1, 32'h100, 32'hFFFF_FFFF, 4'b0011, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h100, 32'h0,         4'h0,    32'h0000FFFF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0F0, 32'h0,         4'h0,    32'h0,        1'b1};
        vecs[4]  = '{1'b1, 32'h200, 32'h1234_5678, 4'hF,    32'h0,        1'b1};
        vecs[5]  = '{1'b0, 32'h200, 32'h0,         4'h0,    32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'h004, 32'hFFFF_FFFF, 4'b0001, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 32'h004, 32'h0,         4'h0,    32'h00000001, 1'b0};
        vecs[8]  = '{1'b1, 32'h000, 32'hFFFF_FFFF, 4'hF,    32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h000, 32'h0,         4'h0,    32'h00000030, 1'b0};
        vecs[10] = '{1'b1, 32'h008, 32'h0000_0055, 4'b1110, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h008, 32'h0,         4'h0,    32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h10C, 32'h0,         4'h0,    32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h102, 32'h0,         4'h0,    32'h0,        1'b1};
        vecs[14] = '{1'b1, 32'h108, 32'hA5A5_A5A5, 4'b1000, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'h108, 32'h0,         4'h0,    32'hA500_0000, 1'b0};
        vecs[16] = '{1'b0, 32'h00C, 32'h0,         4'h0,    32'h0,        1'b0};
        vecs[17] = '{1'b0, 32'h5004, 32'h0,        4'h0,    32'h00000001, 1'b0};
        pick_addr = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h100,
                      32'h104, 32'h108, 32'h10C, 32'h0F0, 32'h102};

        // ---- clock/reset ----
        apb_bus.psel_i = 1'b0; apb_bus.penable_i = 1'b0; apb_bus.pwrite_i = 1'b0;
        apb_bus.paddr_i = 32'h0; apb_bus.pwdata_i = 32'h0; apb_bus.pstrb_i = 4'h0;
        apb_bus.pprot_i = 3'h0;
        div_ack = 1'b0;
        m_reset();
        repeat (3) @(negedge soc_clk);
        check("rst_pready", {31'h0, apb_bus.pready_o}, 32'h0);
        check("rst_pslverr", {31'h0, apb_bus.pslverr_o}, 32'h0);
        check("rst_prdata", apb_bus.prdata_o, 32'h0);
        check("rst_div_req", {31'h0, div_req}, 32'h0);
        check("rst_padmux", padmux[31:0] | padmux[63:32] | padmux[95:64], 32'h0);
        check("rst_bypass_divval", {23'h0, bypass, div_value}, 32'h0);
        soc_rst = 1'b0;

        // ---- directed vector table ----
        for (int i = 0; i < 18; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, err, cyc);
            check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), 32'(cyc), 32'd1);
            if (!vecs[i].wr) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            if (vecs[i].wr && !vecs[i].exp_err) m_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        end
        check("padmux_w0", padmux[31:0], 32'h0000FFFF);
        check("padmux_all", padmux[95:64] ^ padmux[63:32], 32'hA500_0000);
        check("bypass_pin", {31'h0, bypass}, 32'h1);

        // ---- CLKDIV write acked 4 cycles after req ----
        fork
            apb_xfer(1'b1, 32'h008, 32'h0000_0025, 4'h1, rd, err, cyc);
            ack_after(4, 8'h25);
        join
        m_clkdiv = 8'h25;
        check("div_ok_err", {31'h0, err}, 32'h0);
        check("div_ok_lat", 32'(cyc), 32'd7);
        check("div_ok_value", {24'h0, div_value}, 32'h25);
        check("div_ok_req_low", {31'h0, div_req}, 32'h0);
        apb_xfer(1'b0, 32'h008, 32'h0, 4'h0, rd, err, cyc);
        check("div_ok_readback", rd, 32'h25);

        // ---- CLKDIV write never acked: timeout ----
        apb_xfer(1'b1, 32'h008, 32'h0000_0010, 4'h1, rd, err, cyc);
        m_tout = 1'b1;
        check("div_to_err", {31'h0, err}, 32'h1);
        check("div_to_lat", 32'(cyc), 32'd257);
        apb_xfer(1'b0, 32'h00C, 32'h0, 4'h0, rd, err, cyc);
        check("status_sticky", rd, 32'h2);
        apb_xfer(1'b0, 32'h008, 32'h0, 4'h0, rd, err, cyc);
        check("div_to_keep", rd, 32'h25);
        apb_xfer(1'b1, 32'h00C, 32'h2, 4'h1, rd, err, cyc);
        m_tout = 1'b0;
        apb_xfer(1'b0, 32'h00C, 32'h0, 4'h0, rd, err, cyc);
        check("status_w1c", rd, 32'h0);

        // ---- ack in the last wait cycle wins over timeout ----
        fork
            apb_xfer(1'b1, 32'h008, 32'h0000_0099, 4'h1, rd, err, cyc);
            ack_after(254, 8'h99);
        join
        m_clkdiv = 8'h99;
        check("div_edge_err", {31'h0, err}, 32'h0);
        check("div_edge_lat", 32'(cyc), 32'd257);
        apb_xfer(1'b0, 32'h00C, 32'h0, 4'h0, rd, err, cyc);
        check("div_edge_status", rd, 32'h0);

        // ---- random traffic against the model ----
        for (int t = 0; t < 150; t++) begin
            logic        wr;
            logic [31:0] addr, data;
            logic [3:0]  strb;
            int          n;
            wr   = 1'($urandom_range(0, 1));
            addr = pick_addr[$urandom_range(0, 9)] | ($urandom_range(0, 15) << 12);
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if (wr && (addr % 4096) == 8 && strb[0]) begin
                n = $urandom_range(0, 5);
                fork
                    apb_xfer(wr, addr, data, strb, rd, err, cyc);
                    ack_after(n, data[7:0]);
                join
                m_clkdiv = data[7:0];
                check($sformatf("rnd%0d_div_err", t), {31'h0, err}, 32'h0);
                check($sformatf("rnd%0d_div_lat", t), 32'(cyc), 32'(3 + n));
            end else begin
                apb_xfer(wr, addr, data, strb, rd, err, cyc);
                check($sformatf("rnd%0d_err", t), {31'h0, err}, {31'h0, !m_mapped(addr)});
                check($sformatf("rnd%0d_lat", t), 32'(cyc), 32'd1);
                if (!wr && m_mapped(addr)) check($sformatf("rnd%0d_rd", t), rd, m_read(addr));
                if (wr) m_write(addr, data, strb);
            end
        end
        check("rnd_padmux0", padmux[31:0], m_pad[0]);
        check("rnd_padmux1", padmux[63:32], m_pad[1]);
        check("rnd_padmux2", padmux[95:64], m_pad[2]);
        check("rnd_bypass", {31'h0, bypass}, {31'h0, m_bypass});

        // ---- reset asserted mid-WAIT ----
        @(negedge soc_clk);
        apb_bus.psel_i = 1'b1; apb_bus.penable_i = 1'b0; apb_bus.pwrite_i = 1'b1;
        apb_bus.paddr_i = 32'h008; apb_bus.pwdata_i = 32'h77; apb_bus.pstrb_i = 4'h1;
        @(negedge soc_clk);
        apb_bus.penable_i = 1'b1;
        repeat (3) @(negedge soc_clk);
        #1;
        check("midwait_req", {31'h0, div_req}, 32'h1);
        check("midwait_state", {30'h0, dbg_state}, {30'h0, WAIT});
        soc_rst = 1'b1;
        #1;
        check("midwait_rst_req", {31'h0, div_req}, 32'h0);
        check("midwait_rst_pready", {31'h0, apb_bus.pready_o}, 32'h0);
        apb_bus.psel_i = 1'b0; apb_bus.penable_i = 1'b0;
        @(negedge soc_clk);
        soc_rst = 1'b0;
        m_reset();
        check("post_rst_pins", {7'h0, bypass, div_value, padmux[15:0]}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            apb_xfer(1'b0, pick_addr[i], 32'h0, 4'h0, rd, err, cyc);
            check($sformatf("post_rst_rd%0d", i), rd, m_read(pick_addr[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
